// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types and constants.
// The lap feature is compiled in only when STOPWATCH_LAP_EN is defined.
package stopwatch_pkg;

   localparam int NUM_SW_DIGITS = 8;

   // Moduli indexed 0 (centiseconds units) .. 7 (hours tens)
   localparam logic [NUM_SW_DIGITS-1:0][3:0] DIGIT_MOD =
      {4'd10, 4'd10, 4'd6, 4'd10, 4'd6, 4'd10, 4'd10, 4'd10};

   localparam logic [7:0] DP_MASK = 8'b01010100;

`ifdef STOPWATCH_LAP_EN
   typedef enum logic [1:0] {ST_IDLE, ST_RUNNING, ST_PAUSED, ST_LAP} sw_state_e;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_RUNNING, ST_PAUSED} sw_state_e;
`endif

endpackage

// File: rtl/stopwatch_bcd_mod_counter.sv
// Single BCD digit counting 0..MODULUS-1; carry_out fires on the wrapping increment.
module bcd_mod_counter #(
   parameter int unsigned MODULUS = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   output logic [3:0] count_out,
   output logic       carry_out
);

   logic [3:0] count_q, count_d;
   logic       at_max;

   always_comb begin
      at_max    = (count_q == 4'(MODULUS - 1));
      count_d   = count_q;
      if (ena) count_d = at_max ? 4'd0 : count_q + 4'd1;
      carry_out = ena && at_max;
   end

   always_ff @(posedge clk) begin
      if (!rst) count_q <= '0;
      else      count_q <= count_d;
   end

   assign count_out = count_q;

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch control FSM, prescaler and chained BCD digits (HH:MM:SS.cc).
// Define STOPWATCH_LAP_EN to build the LAP state and lap register.
module stopwatch_core
   import stopwatch_pkg::*;
#(
   parameter int TICK_PRESCALER = 1000000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ena,
   input  logic                          start_stop,
   input  logic                          lap_reset,
   output logic [NUM_SW_DIGITS-1:0][3:0] digits_out,
   output logic [7:0]                    dps_out,
   output logic                          running,
   output logic                          overflow
);

   localparam int PW = $clog2(TICK_PRESCALER);

   sw_state_e                     state_q, state_d;
   logic [PW-1:0]                 presc_q, presc_d;
   logic                          running_q, running_d;
   logic                          overflow_q, overflow_d;
   logic                          counting, clear_cnt, cnt_rst;
   logic [NUM_SW_DIGITS:0]        carry;
   logic [NUM_SW_DIGITS-1:0][3:0] count;
`ifdef STOPWATCH_LAP_EN
   logic [NUM_SW_DIGITS-1:0][3:0] lap_q, lap_d;
`endif

   always_comb begin
`ifdef STOPWATCH_LAP_EN
      counting = ena && (state_q == ST_RUNNING || state_q == ST_LAP);
`else
      counting = ena && (state_q == ST_RUNNING);
`endif
      carry[0]  = counting && (presc_q == PW'(TICK_PRESCALER - 1));
      presc_d   = presc_q;
      if (counting) presc_d = carry[0] ? '0 : presc_q + 1'b1;

      state_d   = state_q;
      clear_cnt = 1'b0;
      // start_stop takes priority whenever both pulses arrive together
      if (ena) begin
         case (state_q)
            ST_IDLE:    if (start_stop) state_d = ST_RUNNING;
            ST_RUNNING: begin
               if (start_stop) state_d = ST_PAUSED;
`ifdef STOPWATCH_LAP_EN
               else if (lap_reset) state_d = ST_LAP;
`endif
            end
`ifdef STOPWATCH_LAP_EN
            ST_LAP: begin
               if (start_stop)     state_d = ST_PAUSED;
               else if (lap_reset) state_d = ST_RUNNING;
            end
`endif
            ST_PAUSED: begin
               if (start_stop) state_d = ST_RUNNING;
               else if (lap_reset) begin
                  state_d   = ST_IDLE;
                  clear_cnt = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      if (clear_cnt) presc_d = '0;

      overflow_d = clear_cnt ? 1'b0 : (overflow_q | carry[NUM_SW_DIGITS]);
`ifdef STOPWATCH_LAP_EN
      running_d = (state_d == ST_RUNNING) || (state_d == ST_LAP);
      lap_d     = lap_q;
      if (ena && state_q == ST_RUNNING && lap_reset && !start_stop) lap_d = count;
`else
      running_d = (state_d == ST_RUNNING);
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         presc_q    <= '0;
         running_q  <= 1'b0;
         overflow_q <= 1'b0;
`ifdef STOPWATCH_LAP_EN
         lap_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         running_q  <= running_d;
         overflow_q <= overflow_d;
`ifdef STOPWATCH_LAP_EN
         lap_q      <= lap_d;
`endif
      end
   end

   // Leaving PAUSED for IDLE clears the digits through their synchronous reset
   assign cnt_rst = rst && !clear_cnt;

   for (genvar i = 0; i < NUM_SW_DIGITS; i++) begin : g_digit
      bcd_mod_counter #(.MODULUS(int'(DIGIT_MOD[i]))) u_digit (
         .clk       (clk),
         .rst       (cnt_rst),
         .ena       (carry[i]),
         .count_out (count[i]),
         .carry_out (carry[i+1])
      );
   end

`ifdef STOPWATCH_LAP_EN
   assign digits_out = (state_q == ST_LAP) ? lap_q : count;
`else
   assign digits_out = count;
`endif
   assign dps_out  = DP_MASK;
   assign running  = running_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Stopwatch bench: directed scenarios plus random pulses against a centisecond-count model.
module tb_stopwatch_core;

   localparam int P     = 4;
   localparam int MAXCS = 35999999;
`ifdef STOPWATCH_LAP_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif

   typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_LAP} mst_e;

   logic            clk = 1'b0;
   logic            rst = 1'b0, ena = 1'b0, start_stop = 1'b0, lap_reset = 1'b0;
   logic [7:0][3:0] digits_out;
   logic [7:0]      dps_out;
   logic            running, overflow;

   int          checks = 0, failures = 0;
   mst_e        m_st;
   int          m_presc, m_cs, m_lap;
   bit          m_ovf;
   logic [31:0] pre_d, saved;

   stopwatch_core #(.TICK_PRESCALER(P)) dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .start_stop (start_stop),
      .lap_reset  (lap_reset),
      .digits_out (digits_out),
      .dps_out    (dps_out),
      .running    (running),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] to_bcd(int cs);
      int s, m, h;
      s = (cs / 100) % 60;
      m = (cs / 6000) % 60;
      h = cs / 360000;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
              4'(s / 10), 4'(s % 10), 4'((cs / 10) % 10), 4'(cs % 10)};
   endfunction

   task automatic model_step(bit r, bit e, bit ss, bit lr);
      int old_cs;
      if (!r) begin
         m_st = M_IDLE; m_presc = 0; m_cs = 0; m_lap = 0; m_ovf = 0;
         return;
      end
      if (!e) return;
      old_cs = m_cs;
      if (m_st == M_RUN || m_st == M_LAP) begin
         if (m_presc == P - 1) begin
            m_presc = 0;
            if (m_cs == MAXCS) begin m_cs = 0; m_ovf = 1; end
            else m_cs++;
         end else m_presc++;
      end
      case (m_st)
         M_IDLE:  if (ss) m_st = M_RUN;
         M_RUN:   if (ss) m_st = M_PAUSE;
                  else if (lr && LAP_EN) begin m_st = M_LAP; m_lap = old_cs; end
         M_LAP:   if (ss) m_st = M_PAUSE; else if (lr) m_st = M_RUN;
         M_PAUSE: if (ss) m_st = M_RUN;
                  else if (lr) begin m_st = M_IDLE; m_cs = 0; m_presc = 0; m_ovf = 0; end
         default: m_st = M_IDLE;
      endcase
   endtask

   task automatic cycle(bit r, bit e, bit ss, bit lr);
      @(negedge clk);
      rst = r; ena = e; start_stop = ss; lap_reset = lr;
      @(posedge clk);
      model_step(r, e, ss, lr);
      #1;
      check("digits", digits_out, to_bcd(m_st == M_LAP ? m_lap : m_cs));
      check("running", 32'(running), 32'(m_st == M_RUN || m_st == M_LAP));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("dps", 32'(dps_out), 32'h54);
   endtask

   // Loads a count into the digit flops; stopwatch must be paused so they hold it
   task automatic preload(int cs);
      pre_d = to_bcd(cs);
      force dut.g_digit[0].u_digit.count_q = pre_d[3:0];
      force dut.g_digit[1].u_digit.count_q = pre_d[7:4];
      force dut.g_digit[2].u_digit.count_q = pre_d[11:8];
      force dut.g_digit[3].u_digit.count_q = pre_d[15:12];
      force dut.g_digit[4].u_digit.count_q = pre_d[19:16];
      force dut.g_digit[5].u_digit.count_q = pre_d[23:20];
      force dut.g_digit[6].u_digit.count_q = pre_d[27:24];
      force dut.g_digit[7].u_digit.count_q = pre_d[31:28];
      m_cs = cs;
      cycle(1, 1, 0, 0);
      release dut.g_digit[0].u_digit.count_q;
      release dut.g_digit[1].u_digit.count_q;
      release dut.g_digit[2].u_digit.count_q;
      release dut.g_digit[3].u_digit.count_q;
      release dut.g_digit[4].u_digit.count_q;
      release dut.g_digit[5].u_digit.count_q;
      release dut.g_digit[6].u_digit.count_q;
      release dut.g_digit[7].u_digit.count_q;
   endtask

   initial begin
      int n;
      m_st = M_IDLE; m_presc = 0; m_cs = 0; m_lap = 0; m_ovf = 0;

      // reset wins over ena and pulses
      repeat (3) cycle(0, 1, 1, 1);
      check("rst_digits", digits_out, 32'h0);
      check("rst_running", 32'(running), 32'h0);
      check("rst_overflow", 32'(overflow), 32'h0);

      // 40 cycles after start -> 00:00:00.10
      cycle(1, 1, 1, 0);
      repeat (40) cycle(1, 1, 0, 0);
      check("run40_digits", digits_out, 32'h0000_0010);
      check("run40_running", 32'(running), 32'h1);

      // pause keeps the fractional tick
      cycle(0, 1, 0, 0);
      cycle(1, 1, 1, 0);
      repeat (4000) cycle(1, 1, 0, 0);
      check("preload1000", digits_out, 32'h0000_1000);
      cycle(1, 1, 0, 0);
      cycle(1, 1, 1, 0);
      check("paused_presc2", 32'(m_presc), 32'd2);
      repeat (7) cycle(1, 1, 0, 0);
      cycle(1, 1, 1, 0);
      cycle(1, 1, 0, 0);
      check("resume_1cyc", digits_out, 32'h0000_1000);
      cycle(1, 1, 0, 0);
      check("resume_2cyc", digits_out, 32'h0000_1001);

      // wrap from 99:59:59.99
      cycle(1, 1, 1, 0);
      preload(MAXCS);
      check("max_digits", digits_out, 32'h9959_5999);
      cycle(1, 1, 1, 0);
      n = 0;
      while (!m_ovf && n < 8) begin cycle(1, 1, 0, 0); n++; end
      check("wrap_bound", 32'(m_ovf), 32'h1);
      check("wrap_digits", digits_out, 32'h0);
      check("wrap_overflow", 32'(overflow), 32'h1);
      check("wrap_running", 32'(running), 32'h1);
      repeat (10) cycle(1, 1, 0, 0);
      cycle(1, 1, 1, 0);
      cycle(1, 1, 0, 1);
      check("clr_overflow", 32'(overflow), 32'h0);
      check("clr_running", 32'(running), 32'h0);
      check("clr_digits", digits_out, 32'h0);

`ifdef STOPWATCH_LAP_EN
      // lap freezes the display while counting continues
      cycle(1, 1, 1, 0);
      n = 0;
      while (m_cs != 123 && n < 1000) begin cycle(1, 1, 0, 0); n++; end
      check("lap_reach", 32'(m_cs), 32'd123);
      cycle(1, 1, 0, 1);
      repeat (400) cycle(1, 1, 0, 0);
      check("lap_frozen", digits_out, 32'h0000_0123);
      cycle(1, 1, 0, 1);
      check("lap_release", digits_out, 32'h0000_0223);
`else
      // lap_reset ignored while running
      cycle(1, 1, 1, 0);
      repeat (10) cycle(1, 1, 0, 0);
      cycle(1, 1, 0, 1);
      check("nolap_running", 32'(running), 32'h1);
`endif

      // simultaneous pulses: start_stop wins
      cycle(1, 1, 1, 1);
      check("both_running", 32'(running), 32'h0);
      check("both_digits", digits_out, to_bcd(m_cs));
      cycle(1, 1, 1, 0);
      saved = digits_out;
      repeat (20) cycle(1, 0, 1'($urandom % 2), 1'($urandom % 2));
      check("ena_low_digits", digits_out, saved);
      check("ena_low_running", 32'(running), 32'h1);

      // reset while a carry is about to ripple
      cycle(1, 1, 1, 0);
      preload(5999);
      cycle(1, 1, 1, 0);
      n = 0;
      while (m_presc != P - 1 && n < 8) begin cycle(1, 1, 0, 0); n++; end
      check("carry_pending", 32'(m_presc), 32'(P - 1));
      cycle(0, 1, 0, 0);
      check("rst_carry_digits", digits_out, 32'h0);
      check("rst_carry_running", 32'(running), 32'h0);

      // random pulse traffic
      for (int i = 0; i < 3000; i++)
         cycle(1'(($urandom % 500) != 0), 1'(($urandom % 8) != 0),
               1'(($urandom % 30) == 0), 1'(($urandom % 25) == 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 SHALL have parameter TICK_PRESCALER, default 1000000, clk cycles per 0.01 s count tick (legal range >= 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port ena  input  1  global enable; low = all state held, all pulse inputs ignored.
REQ-005 SHALL have port start_stop  input  1  single-cycle pre-debounced pulse: start/pause/resume.
REQ-006 SHALL have port lap_reset  input  1  single-cycle pre-debounced pulse: lap toggle (running) / clear (paused).
REQ-007 SHALL have port digits_out  output  8x4 packed  BCD digits; index 0 = centiseconds units, index 7 = hours tens.
REQ-008 SHALL have port dps_out  output  8  decimal-point mask, constant 8'b01010100.
REQ-009 SHALL have port running  output  1  high in RUNNING and LAP.
REQ-010 SHALL have port overflow  output  1  sticky wrap flag.

Function
REQ-011 SHALL implement states IDLE, RUNNING, PAUSED, LAP.
REQ-012 IDLE: start_stop -> RUNNING; lap_reset ignored; count held at zero.
REQ-013 RUNNING: start_stop -> PAUSED; lap_reset -> LAP, latching current count into lap register the same edge.
REQ-014 LAP: counting continues; digits_out shows lap register; lap_reset -> RUNNING; start_stop -> PAUSED.
REQ-015 PAUSED: start_stop -> RUNNING; lap_reset -> IDLE, clearing count, prescaler and overflow.
REQ-016 start_stop and lap_reset asserted in the same cycle: start_stop acts, lap_reset discarded.
REQ-017 Prescaler counts only in RUNNING/LAP, 0..TICK_PRESCALER-1; tick at value TICK_PRESCALER-1, then 0.
REQ-018 Prescaler held (not cleared) in PAUSED so resume keeps fractional tick; cleared only on entering IDLE.
REQ-019 Count increments on the same edge the prescaler wraps; digit moduli 10,10,10,6,10,6,10,10 (index 0..7), carry ripple in one cycle.
REQ-020 Max count 99:59:59.99; next tick wraps all digits to 0 and sets overflow; state unchanged.
REQ-021 overflow cleared only by rst or PAUSED->IDLE transition.
REQ-022 digits_out = count register (RUNNING/PAUSED/IDLE) or lap register (LAP), no added latency; no digit ever exceeds its modulus-1.

Reset
REQ-023 rst low at an edge SHALL force IDLE, count 0, lap register 0, prescaler 0, overflow 0, regardless of ena or pulses.
REQ-024 Post-reset outputs: digits_out all 0, dps_out 8'b01010100, running 0, overflow 0.
REQ-025 Reset mid-count or mid-LAP SHALL take effect on that edge, no partial carry retained.

Configuration
REQ-026 Macro STOPWATCH_LAP_EN SHALL gate lap feature.
REQ-027 Defined: LAP state and lap register present as above.
REQ-028 Undefined: no LAP state or lap register; lap_reset in RUNNING ignored; lap_reset in PAUSED still clears to IDLE.

Structure
REQ-029 Package stopwatch_pkg SHALL hold state enum, NUM_SW_DIGITS = 8, per-digit modulus table, DP mask constant.
REQ-030 Sub-module bcd_mod_counter (parameter MODULUS; ports clk, rst, ena, count_out, carry_out) SHALL be instanced once per digit, chained by carry.
REQ-031 Output format SHALL drop directly into the digit drawer's digit/dp inputs without glue logic.

Verification (TICK_PRESCALER = 4)
REQ-032 Reset, start_stop, 40 cycles -> digits_out = 00:00:00.10, running = 1.
REQ-033 Preload via 1000 ticks, pause at prescaler = 2, resume -> next increment after exactly 2 cycles, not 4.
REQ-034 Count 99:59:59.99 (force), one tick -> all digits 0, overflow = 1, state RUNNING; pause + lap_reset -> overflow = 0, IDLE.
REQ-035 LAP_EN: lap_reset at 00:00:01.23, run 100 ticks -> digits_out stays 01.23; lap_reset -> shows 00:00:02.23.
REQ-036 start_stop and lap_reset same cycle in RUNNING -> PAUSED, lap register unchanged; ena low 20 cycles -> digits frozen, pulses ignored.
REQ-037 rst asserted while digit carry pending at 00:00:59.99 -> next cycle all zero, IDLE, running = 0.
